db_read_sequencer: RTL and testbench

- Read-side controller for the memory core's double-buffer (tile) mode; the consumer counterpart to the write-side fill logic.
- Tracks two SRAM banks: one fills from writer strobes while the other drains through a strided, up-to-3-D address loop.
- Issues SRAM reads and returns data with a valid flag.
- Swaps banks when a bank has been fully written and the bank being read has been fully drained.

---
 rtl/db_read_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_db_read_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_read_sequencer.sv
// Double-buffer read sequencer: one bank fills from writer strobes while the other
// drains through a strided up-to-3-D address loop; banks swap on fill+drain completion.
module db_read_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] depth,
  input  logic [CNT_WIDTH-1:0]  iter_cnt,
  input  logic [ADDR_WIDTH-1:0] starting_addr,
  input  logic [1:0]            dimensionality,
  input  logic [ADDR_WIDTH-1:0] stride_0,
  input  logic [ADDR_WIDTH-1:0] stride_1,
  input  logic [ADDR_WIDTH-1:0] stride_2,
  input  logic [CNT_WIDTH-1:0]  range_0,
  input  logic [CNT_WIDTH-1:0]  range_1,
  input  logic [CNT_WIDTH-1:0]  range_2,
  input  logic                  wen_in,
  output logic                  wr_ready,
  input  logic                  ren_in,
  output logic                  sram_ren,
  output logic                  sram_bank,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  bank_swap,
  output logic                  overflow
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic [ADDR_WIDTH-1:0] wcount_q, wcount_d;
  logic [CNT_WIDTH-1:0]  rcount_q, rcount_d;
  logic [CNT_WIDTH-1:0]  idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
  logic                  sram_ren_q, sram_bank_q, valid_out_q, bank_swap_q, overflow_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  issue, drain_done, wr_accept, fill_done, dim1_en, dim2_en;
  logic [ADDR_WIDTH-1:0] addr;

  // Index is reduced to the address width before the multiply so the product wraps there.
  function automatic logic [ADDR_WIDTH-1:0] addr_term(input logic [CNT_WIDTH-1:0] idx,
                                                      input logic [ADDR_WIDTH-1:0] stride);
    logic [ADDR_WIDTH-1:0] idx_t;
    idx_t = ADDR_WIDTH'(idx);
    return idx_t * stride;
  endfunction

  assign wr_ready  = clk_en & ~full_q[wr_bank_q];
  assign wr_accept = wen_in & wr_ready;
  assign fill_done = wr_accept && (wcount_q == depth - ADDR_WIDTH'(1));
  assign dim1_en   = (dimensionality >= 2'd2);
  assign dim2_en   = (dimensionality == 2'd3);
  assign addr      = starting_addr + addr_term(idx0_q, stride_0)
                   + addr_term(idx1_q, stride_1) + addr_term(idx2_q, stride_2);

  always_ff @(posedge clk) begin
    if (reset || flush) state_q <= S_IDLE;
    else if (clk_en)    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (full_q[rd_bank_q]) state_d = S_DRAIN;
      S_DRAIN: if (drain_done)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue      = (state_q == S_DRAIN) & clk_en & ren_in;
    drain_done = issue && (rcount_q == iter_cnt - CNT_WIDTH'(1));
  end

  // Loop counters: inactive dims never advance, so they stay at their cleared value.
  always_comb begin
    rcount_d = rcount_q;
    idx0_d   = idx0_q;
    idx1_d   = idx1_q;
    idx2_d   = idx2_q;
    if (drain_done) begin
      rcount_d = '0;
      idx0_d   = '0;
      idx1_d   = '0;
      idx2_d   = '0;
    end else if (issue) begin
      rcount_d = rcount_q + CNT_WIDTH'(1);
      if (idx0_q == range_0 - CNT_WIDTH'(1)) begin
        idx0_d = '0;
        if (dim1_en) begin
          if (idx1_q == range_1 - CNT_WIDTH'(1)) begin
            idx1_d = '0;
            if (dim2_en) begin
              if (idx2_q == range_2 - CNT_WIDTH'(1)) idx2_d = '0;
              else                                   idx2_d = idx2_q + CNT_WIDTH'(1);
            end
          end else begin
            idx1_d = idx1_q + CNT_WIDTH'(1);
          end
        end
      end else begin
        idx0_d = idx0_q + CNT_WIDTH'(1);
      end
    end
  end

  // A fill and a release always target different banks, so both updates compose.
  always_comb begin
    full_d    = full_q;
    wcount_d  = wcount_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_accept) begin
      if (fill_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wcount_d          = '0;
      end else begin
        wcount_d = wcount_q + ADDR_WIDTH'(1);
      end
    end
    if (drain_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      wcount_q    <= '0;
      rcount_q    <= '0;
      idx0_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      sram_ren_q  <= 1'b0;
      sram_bank_q <= 1'b0;
      sram_addr_q <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      bank_swap_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // Return path runs ungated so an issued read completes even if clk_en drops.
      sram_ren_q  <= issue;
      bank_swap_q <= drain_done;
      valid_out_q <= sram_ren_q;
      if (sram_ren_q) data_out_q <= sram_rdata;
      if (clk_en) begin
        wr_bank_q <= wr_bank_d;
        rd_bank_q <= rd_bank_d;
        full_q    <= full_d;
        wcount_q  <= wcount_d;
        rcount_q  <= rcount_d;
        idx0_q    <= idx0_d;
        idx1_q    <= idx1_d;
        idx2_q    <= idx2_d;
        if (wen_in && full_q[wr_bank_q]) overflow_q <= 1'b1;
        if (issue) begin
          sram_addr_q <= addr;
          sram_bank_q <= rd_bank_q;
        end
      end
    end
  end

  assign sram_ren  = sram_ren_q;
  assign sram_bank = sram_bank_q;
  assign sram_addr = sram_addr_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign bank_swap = bank_swap_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_db_read_sequencer.sv
// Scoreboard bench for db_read_sequencer: expected read addresses/banks are queued
// when a drain is set up and compared as the DUT issues reads and returns data.
module tb_db_read_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, clk_en, flush, wen_in, ren_in, ovr_rdata;
  logic [AW-1:0] depth, starting_addr, stride_0, stride_1, stride_2;
  logic [CW-1:0] iter_cnt, range_0, range_1, range_2;
  logic [1:0]    dimensionality;
  logic          wr_ready, sram_ren, sram_bank, valid_out, bank_swap, overflow;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata, data_out;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          bank;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] dq[$];
  int            dcyc_q[$];
  rd_t           mon_e;
  int            total = 0, bad = 0, cyc = 0;
  int            drain_issues = 0, ren_total = 0, exp_iter = 0;

  db_read_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .depth(depth), .iter_cnt(iter_cnt), .starting_addr(starting_addr),
    .dimensionality(dimensionality),
    .stride_0(stride_0), .stride_1(stride_1), .stride_2(stride_2),
    .range_0(range_0), .range_1(range_1), .range_2(range_2),
    .wen_in(wen_in), .wr_ready(wr_ready), .ren_in(ren_in),
    .sram_ren(sram_ren), .sram_bank(sram_bank), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .data_out(data_out), .valid_out(valid_out),
    .bank_swap(bank_swap), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic b);
    return {a[7:0], a[15:8]} ^ (b ? 16'hC3C3 : 16'h0000);
  endfunction

  assign sram_rdata = ovr_rdata ? 16'hA5A5 : mem_word(sram_addr, sram_bank);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (dq.size() == 0) chk("valid_unexpected", 1, 0);
      else begin
        chk("rdata", data_out, dq.pop_front());
        chk("latency", cyc - dcyc_q.pop_front(), 1);
      end
    end
    if (sram_ren) begin
      drain_issues++;
      ren_total++;
      if (exp_q.size() == 0) chk("ren_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("addr", sram_addr, mon_e.addr);
        chk("bank", sram_bank, mon_e.bank);
        dq.push_back(ovr_rdata ? 16'hA5A5 : mem_word(mon_e.addr, mon_e.bank));
        dcyc_q.push_back(cyc);
      end
    end
    if (bank_swap) begin
      chk("swap_pos", drain_issues, exp_iter);
      drain_issues = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    dq.delete();
    dcyc_q.delete();
    drain_issues = 0;
    ren_total    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; wen_in = 1'b0; ren_in = 1'b0; flush = 1'b0; clk_en = 1'b1;
    tick(2);
    clear_sb();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input int d, input int it, input int st, input int dim,
                         input int s0, input int s1, input int s2,
                         input int r0, input int r1, input int r2);
    depth = AW'(d); iter_cnt = CW'(it); starting_addr = AW'(st); dimensionality = 2'(dim);
    stride_0 = AW'(s0); stride_1 = AW'(s1); stride_2 = AW'(s2);
    range_0 = CW'(r0); range_1 = CW'(r1); range_2 = CW'(r2);
    exp_iter = it;
  endtask

  // Reference address stream from a closed-form decomposition of the issue number.
  task automatic push_drain(input logic b);
    rd_t e;
    int  i0, i1, i2, a, r0, r1, r2;
    r0 = int'(range_0); r1 = int'(range_1); r2 = int'(range_2);
    for (int i = 0; i < int'(iter_cnt); i++) begin
      i0 = i % r0;
      i1 = (dimensionality >= 2) ? (i / r0) % r1 : 0;
      i2 = (dimensionality == 3) ? (i / (r0 * r1)) % r2 : 0;
      a  = int'(starting_addr) + i0 * int'(stride_0) + i1 * int'(stride_1) + i2 * int'(stride_2);
      e.addr = AW'(a);
      e.bank = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic write_n(input int n);
    wen_in = 1'b1;
    tick(n);
    wen_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || dq.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    chk("drain_timeout", exp_q.size() + dq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k;
    ovr_rdata = 1'b0;
    set_cfg(9, 27, 0, 3, 1, 3, 9, 3, 3, 3);
    do_reset();

    chk("rst_sram_ren", sram_ren, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_bank", sram_bank, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_bank_swap", bank_swap, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // basic 3-D fill/drain
    push_drain(1'b0);
    write_n(9);
    ren_in = 1'b1;
    wait_done(200);
    tick(4);
    chk("basic_ren_total", ren_total, 27);
    chk("basic_wr_ready", wr_ready, 1);
    ren_in = 1'b0;

    // ping-pong with a continuous writer
    do_reset();
    set_cfg(4, 4, 0, 1, 1, 0, 0, 4, 1, 1);
    for (int d = 0; d < 4; d++) push_drain(1'(d % 2));
    ren_in = 1'b1;
    w = 0; k = 0;
    while ((w < 16 || exp_q.size() != 0) && k < 400) begin
      wen_in = (w < 16) && wr_ready;
      if (wen_in) w++;
      tick(1);
      k++;
    end
    wen_in = 1'b0;
    wait_done(50);
    chk("pp_writes", w, 16);
    chk("pp_overflow", overflow, 0);
    ren_in = 1'b0;

    // back-pressure: both banks full, extra write dropped
    do_reset();
    set_cfg(4, 4, 0, 1, 1, 0, 0, 4, 1, 1);
    write_n(8);
    tick(2);
    chk("bp_wr_ready", wr_ready, 0);
    chk("bp_overflow_pre", overflow, 0);
    write_n(1);
    chk("bp_overflow", overflow, 1);
    tick(5);
    chk("bp_overflow_sticky", overflow, 1);
    push_drain(1'b0);
    push_drain(1'b1);
    ren_in = 1'b1;
    wait_done(100);
    tick(2);
    chk("bp_wr_ready_after", wr_ready, 1);
    write_n(3);
    tick(10);
    chk("bp_no_extra_drain", ren_total, 8);
    chk("bp_overflow_end", overflow, 1);
    ren_in = 1'b0;

    // latency with fixed read data, depth=1
    do_reset();
    set_cfg(1, 1, 16'h1234, 1, 0, 0, 0, 1, 1, 1);
    ovr_rdata = 1'b1;
    push_drain(1'b0);
    write_n(1);
    ren_in = 1'b1;
    k = 0;
    while (!sram_ren && k < 20) begin tick(1); k++; end
    chk("lat_ren", sram_ren, 1);
    ren_in = 1'b0;
    tick(1);
    chk("lat_valid", valid_out, 1);
    chk("lat_data", data_out, 16'hA5A5);
    tick(1);
    chk("lat_valid_clear", valid_out, 0);
    chk("lat_data_hold", data_out, 16'hA5A5);
    ovr_rdata = 1'b0;
    push_drain(1'b1);
    write_n(1);
    ren_in = 1'b1;
    wait_done(50);
    ren_in = 1'b0;

    // address wrap, with a clk_en gap mid-drain
    do_reset();
    set_cfg(4, 4, 16'hFFFE, 1, 1, 0, 0, 4, 1, 1);
    push_drain(1'b0);
    write_n(4);
    ren_in = 1'b1;
    k = 0;
    while (drain_issues < 2 && k < 50) begin tick(1); k++; end
    clk_en = 1'b0;
    tick(2);
    chk("ce_no_issue", sram_ren, 0);
    chk("ce_wr_ready", wr_ready, 0);
    tick(1);
    clk_en = 1'b1;
    wait_done(50);
    ren_in = 1'b0;

    // reset in the middle of a drain
    do_reset();
    set_cfg(9, 27, 16'h0100, 3, 1, 3, 9, 3, 3, 3);
    push_drain(1'b0);
    write_n(9);
    ren_in = 1'b1;
    k = 0;
    while (drain_issues < 5 && k < 100) begin @(negedge clk); #1; k++; end
    chk("mid_issues", drain_issues, 5);
    reset = 1'b1;
    ren_in = 1'b0;
    clear_sb();
    tick(1);
    chk("mid_sram_ren", sram_ren, 0);
    chk("mid_sram_addr", sram_addr, 0);
    chk("mid_valid_out", valid_out, 0);
    chk("mid_data_out", data_out, 0);
    chk("mid_bank_swap", bank_swap, 0);
    chk("mid_wr_ready", wr_ready, 1);
    reset = 1'b0;
    tick(1);
    push_drain(1'b0);
    write_n(9);
    ren_in = 1'b1;
    wait_done(200);
    ren_in = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
